// File: rtl/sc_demux101_deserializer.sv
// Serial-to-parallel demultiplexer: steers serial bits into ten per-channel shift
// registers and publishes each completed word with a one-cycle done strobe.
module sc_demux101_deserializer #(
  parameter int unsigned DEMUX101_SELECTWIDTH = 4,
  parameter int unsigned DEMUX101_DATAWIDTH   = 8
) (
  input  logic                          SC_DEMUX101_CLOCK_50,
  input  logic                          SC_DEMUX101_RESET_InHigh,
  input  logic [DEMUX101_SELECTWIDTH-1:0] SC_DEMUX101_select_InBUS,
  input  logic                          SC_DEMUX101_data_In,
  input  logic                          SC_DEMUX101_valid_In,
  input  logic                          SC_DEMUX101_flush_In,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data1_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data2_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data3_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data4_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data5_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data6_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data7_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data8_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data9_OutBUS,
  output logic [DEMUX101_DATAWIDTH-1:0] SC_DEMUX101_data10_OutBUS,
  output logic [9:0]                    SC_DEMUX101_done_OutBUS,
  output logic                          SC_DEMUX101_err_Out
);

  localparam int unsigned NCH = 10;
  localparam int unsigned SW  = DEMUX101_SELECTWIDTH;
  localparam int unsigned DW  = DEMUX101_DATAWIDTH;
  localparam int unsigned CW  = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] sh   [NCH];
  logic [CW-1:0] cnt  [NCH];
  logic [DW-1:0] word [NCH];
  logic          sel_ok;

  assign sel_ok = (SC_DEMUX101_select_InBUS < SW'(NCH));

  // Priority: reset, then flush, then an accepted or rejected valid bit.
  always_ff @(posedge SC_DEMUX101_CLOCK_50) begin
    if (SC_DEMUX101_RESET_InHigh) begin
      for (int n = 0; n < NCH; n++) begin
        sh[n]   <= '0;
        cnt[n]  <= '0;
        word[n] <= '0;
      end
      SC_DEMUX101_done_OutBUS <= '0;
      SC_DEMUX101_err_Out     <= 1'b0;
    end else begin
      SC_DEMUX101_done_OutBUS <= '0;
      SC_DEMUX101_err_Out     <= 1'b0;
      if (SC_DEMUX101_flush_In) begin
        for (int n = 0; n < NCH; n++) begin
          sh[n]  <= '0;
          cnt[n] <= '0;
        end
      end else if (SC_DEMUX101_valid_In) begin
        if (!sel_ok) begin
          SC_DEMUX101_err_Out <= 1'b1;
        end else begin
          for (int n = 0; n < NCH; n++) begin
            if (SC_DEMUX101_select_InBUS == SW'(n)) begin
              sh[n] <= {sh[n][DW-2:0], SC_DEMUX101_data_In};
              if (cnt[n] == CW'(DW - 1)) begin
                word[n]                    <= {sh[n][DW-2:0], SC_DEMUX101_data_In};
                cnt[n]                     <= '0;
                SC_DEMUX101_done_OutBUS[n] <= 1'b1;
              end else begin
                cnt[n] <= cnt[n] + CW'(1);
              end
            end
          end
        end
      end
    end
  end

  assign SC_DEMUX101_data1_OutBUS  = word[0];
  assign SC_DEMUX101_data2_OutBUS  = word[1];
  assign SC_DEMUX101_data3_OutBUS  = word[2];
  assign SC_DEMUX101_data4_OutBUS  = word[3];
  assign SC_DEMUX101_data5_OutBUS  = word[4];
  assign SC_DEMUX101_data6_OutBUS  = word[5];
  assign SC_DEMUX101_data7_OutBUS  = word[6];
  assign SC_DEMUX101_data8_OutBUS  = word[7];
  assign SC_DEMUX101_data9_OutBUS  = word[8];
  assign SC_DEMUX101_data10_OutBUS = word[9];

endmodule

// File: doc/sc_demux101_deserializer.md
# sc_demux101_deserializer

Registered 1-to-10 serial demultiplexer and deserializer. It is the write side of the ten-input word multiplexer. A serial bit stream arrives with a 4-bit channel select. The block steers each bit into one of ten per-channel shift registers. When a channel has collected a full word, that word is published on the channel's parallel output bus together with a one-cycle done strobe. It sits between the serial front end and the bank of data buses that the downstream multiplexer selects from.

## Interface
- DEMUX101_SELECTWIDTH, 4: width of the channel select bus.
- DEMUX101_DATAWIDTH, 8: bits per word and width of each output bus.
- SC_DEMUX101_CLOCK_50  in  1: system clock; all state changes on the rising edge.
- SC_DEMUX101_RESET_InHigh  in  1: reset, synchronous and active-high.
- SC_DEMUX101_select_InBUS  in  SELECTWIDTH: destination channel, 0..9 valid.
- SC_DEMUX101_data_In  in  1: serial data bit.
- SC_DEMUX101_valid_In  in  1: data_In and select_InBUS are sampled when this is high.
- SC_DEMUX101_flush_In  in  1: discard all partial words.
- SC_DEMUX101_data1_OutBUS … SC_DEMUX101_data10_OutBUS  out  DATAWIDTH each: last complete word of channels 0..9.
- SC_DEMUX101_done_OutBUS  out  10: bit n pulses for one cycle when channel n publishes a word.
- SC_DEMUX101_err_Out  out  1: one-cycle pulse when a valid bit carries a select value ≥ 10.

## Operation
- Per-channel state:
  - shift register sh[n], DATAWIDTH bits;
  - bit counter cnt[n], 0..DATAWIDTH-1 (3 bits at default);
  - output register out[n].
- Accepted bit: valid_In=1 and flush_In=0 and select s<10. For an accepted bit:
  - sh[s] <= {sh[s][DATAWIDTH-2:0], data_In}. Words are MSB first: the first bit received ends up in bit DATAWIDTH-1.
  - If cnt[s] < DATAWIDTH-1, cnt[s] increments.
  - If cnt[s] == DATAWIDTH-1:
    - out[s] <= {sh[s][DATAWIDTH-2:0], data_In};
    - cnt[s] <= 0;
    - done[s] is high for the following cycle.
  - Channels other than s are untouched.
- Invalid select: valid_In=1 and flush_In=0 and s≥10.
  - The bit is dropped.
  - err_Out is high for the following cycle.
  - No shift register, counter or output changes. This mirrors the multiplexer holding its output for out-of-range selects.
- valid_In=0: no state change; done and err go low.
- Flush: when flush_In=1, every sh[n] and cnt[n] is cleared.
  - out[n] is retained.
  - The input bit is dropped, even if valid_In=1.
  - done and err stay low.
  - Flush has priority over valid_In.
- Interleaving: select may change on any cycle. Each channel keeps its partial word and count independently, so words to different channels can be interleaved bit by bit.
- Reset: when RESET_InHigh=1 at a rising edge, all sh, cnt and out are cleared to 0. done_OutBUS=0 and err_Out=0. Reset has priority over flush and valid_In. A reset in the middle of a word discards that word.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Publish latency: the last bit of a word is sampled at edge k. At edge k the new word appears on dataN_OutBUS and done[n] goes high. done[n] falls at edge k+1 unless another word completes on the same channel at k+1. That cannot happen for DATAWIDTH > 1.
- Throughput: one bit per cycle, so at most one word per DATAWIDTH cycles per channel and in aggregate.
- done_OutBUS is one-hot or zero, because at most one bit is accepted per cycle.
- err_Out rises at the edge that samples the bad select and is high for exactly one cycle per offending bit.
- dataN_OutBUS changes only on a publish of channel n or on reset.

## Test plan
- Reset, then send bits 1,0,1,0,0,1,0,1 to select=0 with valid_In held high.
  - data1_OutBUS=8'hA5.
  - done_OutBUS=10'b0000000001 for exactly one cycle, beginning at the edge that samples the 8th bit.
  - All other buses stay 0.
- Interleave 8'h3C on select=2 and 8'hF0 on select=9, alternating one bit at a time.
  - data3=8'h3C is published with done[2] on cycle 15.
  - data10=8'hF0 is published with done[9] on cycle 16.
- Send 3 bits on select=4, then a valid bit with select=12.
  - err_Out pulses once.
  - cnt[4] is still 3; 5 further bits complete the word correctly.
- Send 5 bits of 8'hFF on select=1, assert flush_In with valid_In=1 for one cycle, then send a full 8'h81.
  - data2=8'h81.
  - No done during the flush cycle.
  - The earlier data2 value is held until publish.
- Publish 8'h55 on channel 5, start a second word, and assert reset after its 4th bit.
  - All outputs are 0 on the next cycle.
  - The next full 8 bits publish cleanly.
- Send two back-to-back words 8'h01 then 8'h80 on select=7 with valid_In continuously high.
  - done[7] pulses on cycles 8 and 16.
  - data8 holds 8'h01 during cycles 8..15, then 8'h80.
